// File: rtl/bus_arbiter_ctrl_if.sv
// bus_arbiter_ctrl_if: request/grant and bus-select signals between requesters and the arbiter
interface bus_arbiter_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int SRC_W = 4,
  parameter int DST_W = 16
);
  logic [NREQ-1:0]       req;
  logic [NREQ*SRC_W-1:0] src_sel;
  logic [NREQ*4-1:0]     dst_sel;
  logic [NREQ-1:0]       gnt;
  logic [SRC_W-1:0]      read_en;
  logic [DST_W-1:0]      write_en;
  logic                  busy;
  logic                  done;
  logic                  err;
  modport master (output req, src_sel, dst_sel, input gnt, read_en, write_en, busy, done, err);
  modport slave  (input req, src_sel, dst_sel, output gnt, read_en, write_en, busy, done, err);
endinterface

// File: rtl/bus_arbiter_ctrl.sv
// bus_arbiter_ctrl: round-robin arbiter sequencing two-cycle register-to-register bus moves
module bus_arbiter_ctrl #(
  parameter int NREQ  = 4,
  parameter int SRC_W = 4,
  parameter int DST_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  bus_arbiter_ctrl_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, DRIVE, WRITE, ERR} state_t;
  state_t            state, state_d;
  logic [PW-1:0]     ptr, ptr_d, w, w_d, win, idx;
  logic [SRC_W-1:0]  src, src_d, cand_src;
  logic [3:0]        dst, dst_d, cand_dst;
  logic              found, valid;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    cand_src = bus.src_sel[int'(win)*SRC_W +: SRC_W];
    cand_dst = bus.dst_sel[int'(win)*4 +: 4];
    valid = (cand_src inside {3, 4, 5, 7, 8, 9, 10, 12, 13}) && cand_dst != 4'd0;
    state_d = state;
    ptr_d = ptr;
    w_d = w;
    src_d = src;
    dst_d = dst;
    if (state == IDLE && found) begin
      w_d = win;
      src_d = cand_src;
      dst_d = cand_dst;
      state_d = valid ? DRIVE : ERR;
    end else if (state == DRIVE) begin
      state_d = WRITE;
    end else if (state != IDLE) begin
      state_d = IDLE;
      ptr_d = (w == PW'(NREQ - 1)) ? '0 : w + 1'b1;
    end
  end
  // Outputs are registered decodes of the current state, so they trail it by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      w <= '0;
      src <= '0;
      dst <= '0;
      bus.gnt <= '0;
      bus.read_en <= '0;
      bus.write_en <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      w <= w_d;
      src <= src_d;
      dst <= dst_d;
      bus.gnt <= (state != IDLE) ? NREQ'(1) << w : '0;
      bus.read_en <= (state == DRIVE || state == WRITE) ? src : '0;
      bus.write_en <= (state == WRITE) ? DST_W'(1) << dst : '0;
      bus.busy <= state != IDLE;
      bus.done <= state == WRITE;
      bus.err <= state == ERR;
    end
  end
endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// tb_bus_arbiter_ctrl: vector table, corner sequences and random run against a transaction-queue model
module tb_bus_arbiter_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  bus_arbiter_ctrl_if #(.NREQ(4), .SRC_W(4), .DST_W(16)) bus ();
  bus_arbiter_ctrl #(.NREQ(4), .SRC_W(4), .DST_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [3:0]  req;
    logic [15:0] src;
    logic [15:0] dst;
    logic [26:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [26:0] mq[$];
  int m_ptr;
  int valid_src[9] = '{3, 4, 5, 7, 8, 9, 10, 12, 13};
  function automatic logic [26:0] pk(logic [3:0] g, logic [3:0] r, logic [15:0] we, logic d, logic e, logic b);
    return {g, r, we, d, e, b};
  endfunction
  function automatic logic [26:0] act();
    return {bus.gnt, bus.read_en, bus.write_en, bus.done, bus.err, bus.busy};
  endfunction
  function automatic vec_t v(logic [3:0] r, logic [15:0] s, logic [15:0] d, logic [26:0] e);
    vec_t x;
    x.req = r;
    x.src = s;
    x.dst = d;
    x.exp = e;
    return x;
  endfunction
  function automatic bit src_ok(int s);
    foreach (valid_src[k]) if (valid_src[k] == s) return 1'b1;
    return 1'b0;
  endfunction
  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask
  // Each granted transfer becomes a list of future output cycles; arbitration only when nothing is pending
  task automatic model_step(output logic [26:0] o);
    o = '0;
    if (mq.size() > 0) o = mq.pop_front();
    else
      for (int k = 0; k < 4; k++) begin
        int c;
        int s;
        int d;
        c = (m_ptr + k) % 4;
        if (bus.req[c]) begin
          s = int'(bus.src_sel[c*4 +: 4]);
          d = int'(bus.dst_sel[c*4 +: 4]);
          m_ptr = (c + 1) % 4;
          if (src_ok(s) && d != 0) begin
            mq.push_back(pk(4'(1 << c), 4'(s), 16'h0, 1'b0, 1'b0, 1'b1));
            mq.push_back(pk(4'(1 << c), 4'(s), 16'(1 << d), 1'b1, 1'b0, 1'b1));
          end else mq.push_back(pk(4'(1 << c), 4'h0, 16'h0, 1'b0, 1'b1, 1'b1));
          break;
        end
      end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic [3:0] r, logic [15:0] s, logic [15:0] d);
    bus.req = r;
    bus.src_sel = s;
    bus.dst_sel = d;
  endtask
  initial begin
    logic [26:0] o;
    rst_n = 1'b0;
    drive(4'b1111, 16'h3333, 16'h1111);
    #1;
    chk("reset_async_gnt", 32'(bus.gnt), 32'h0);
    repeat (3) tick();
    chk("reset_gnt", 32'(bus.gnt), 32'h0);
    chk("reset_read_en", 32'(bus.read_en), 32'h0);
    chk("reset_write_en", 32'(bus.write_en), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    tbl.push_back(v(4'b1111, 16'h3333, 16'h1111, pk(4'h0, 4'h0, 16'h0000, 0, 0, 0)));
    tbl.push_back(v(4'b1111, 16'h3333, 16'h1111, pk(4'h1, 4'h3, 16'h0000, 0, 0, 1)));
    tbl.push_back(v(4'b1111, 16'h3333, 16'h1111, pk(4'h1, 4'h3, 16'h0002, 1, 0, 1)));
    tbl.push_back(v(4'b0010, 16'h0050, 16'h0070, pk(4'h0, 4'h0, 16'h0000, 0, 0, 0)));
    tbl.push_back(v(4'b0010, 16'h0050, 16'h0070, pk(4'h2, 4'h5, 16'h0000, 0, 0, 1)));
    tbl.push_back(v(4'b0000, 16'h0050, 16'h0070, pk(4'h2, 4'h5, 16'h0080, 1, 0, 1)));
    tbl.push_back(v(4'b0000, 16'h0050, 16'h0070, pk(4'h0, 4'h0, 16'h0000, 0, 0, 0)));
    for (int r = 0; r < 4; r++) begin
      logic [3:0] g;
      logic [15:0] we;
      g = (r == 1) ? 4'h1 : (r == 2) ? 4'h2 : 4'h8;
      we = (r == 1) ? 16'h0002 : (r == 2) ? 16'h0004 : 16'h0010;
      tbl.push_back(v(4'b1011, 16'h4444, 16'h4321, pk(4'h0, 4'h0, 16'h0, 0, 0, 0)));
      tbl.push_back(v(4'b1011, 16'h4444, 16'h4321, pk(g, 4'h4, 16'h0, 0, 0, 1)));
      tbl.push_back(v(4'b1011, 16'h4444, 16'h4321, pk(g, 4'h4, we, 1, 0, 1)));
    end
    tbl.push_back(v(4'b0100, 16'h0600, 16'h0100, pk(4'h0, 4'h0, 16'h0, 0, 0, 0)));
    tbl.push_back(v(4'b0100, 16'h0600, 16'h0100, pk(4'h4, 4'h0, 16'h0, 0, 1, 1)));
    tbl.push_back(v(4'b0100, 16'h0D00, 16'h0000, pk(4'h0, 4'h0, 16'h0, 0, 0, 0)));
    tbl.push_back(v(4'b0100, 16'h0D00, 16'h0000, pk(4'h4, 4'h0, 16'h0, 0, 1, 1)));
    tbl.push_back(v(4'b0000, 16'h0D00, 16'h0000, pk(4'h0, 4'h0, 16'h0, 0, 0, 0)));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].src, tbl[i].dst);
      tick();
      chk($sformatf("vec%0d", i), 32'(act()), 32'(tbl[i].exp));
    end
    drive(4'b0001, 16'h0007, 16'h0009);
    tick();
    tick();
    chk("mid_drive_read_en", 32'(bus.read_en), 32'h7);
    drive(4'b0000, 16'h000C, 16'h0002);
    tick();
    chk("mid_write_read_en", 32'(bus.read_en), 32'h7);
    chk("mid_write_write_en", 32'(bus.write_en), 32'h0200);
    chk("mid_write_done", 32'(bus.done), 32'h1);
    tick();
    chk("mid_after_busy", 32'(bus.busy), 32'h0);
    drive(4'b0010, 16'h0080, 16'h00F0);
    repeat (3) tick();
    chk("abort_write_en_pre", 32'(bus.write_en), 32'h8000);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_write_en", 32'(bus.write_en), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    tick();
    rst_n = 1'b1;
    drive(4'b1111, 16'h3333, 16'h1111);
    tick();
    tick();
    chk("abort_ptr_gnt", 32'(bus.gnt), 32'h1);
    rst_n = 1'b0;
    drive(4'b0000, 16'h0, 16'h0);
    tick();
    rst_n = 1'b1;
    mq.delete();
    m_ptr = 0;
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] s;
      logic [15:0] d;
      for (int k = 0; k < 4; k++) begin
        s[k*4 +: 4] = ($urandom_range(3) != 0) ? 4'(valid_src[$urandom_range(8)]) : 4'($urandom_range(15));
        d[k*4 +: 4] = ($urandom_range(9) != 0) ? 4'($urandom_range(15, 1)) : 4'h0;
      end
      drive(($urandom_range(4) == 0) ? 4'h0 : 4'($urandom_range(15)), s, d);
      model_step(o);
      tick();
      chk($sformatf("rand%0d", n), 32'(act()), 32'(o));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_ctrl.md
Name: bus_arbiter_ctrl

Overview:
Round-robin arbiter and transfer sequencer for the shared 17-bit datapath bus. Up to NREQ requesters (control units, DMA, debug port) each post a transfer: a bus source code plus a destination code. The block grants one requester at a time and drives the bus mux read_en select. It then pulses the one-hot destination write enable, so every register-to-register move is a clean two-cycle sequence with no bus contention.

Parameters:
NREQ, 4, number of requesters (2..8)
SRC_W, 4, width of bus source select code (read_en)
DST_W, 16, width of one-hot destination write-enable vector

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester transfer request, level; held until done
src_sel  input  NREQ*SRC_W  per-requester source code, slice i = bits [i*SRC_W +: SRC_W]
dst_sel  input  NREQ*4  per-requester destination code, slice i = bits [i*4 +: 4]
gnt  output  NREQ  one-hot grant, registered
read_en  output  SRC_W  bus mux source select, registered
write_en  output  DST_W  one-hot destination strobe, registered
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse on transfer completion, qualified by gnt
err  output  1  one-cycle pulse on rejected request, qualified by gnt

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, read_en=0, write_en=0, busy=0, done=0, err=0, rr pointer=0. All outputs take these values immediately, independent of clk. The first edge after deassertion samples normally.
- States: IDLE, DRIVE, WRITE, ERR.
- IDLE: if any req is high, pick the winner by round-robin. Search order starts at requester ptr and wraps modulo NREQ. Latch the winner's src_sel and dst_sel.
  - Valid source codes: 3, 4, 5, 7, 8, 9, 10, 12, 13.
  - Valid destination codes: 1..15. Code 0 is invalid.
- IDLE with valid codes -> DRIVE. With any invalid code -> ERR. With no req -> stay in IDLE with all outputs 0.
- DRIVE (1 cycle): gnt[w]=1, read_en=latched src, write_en=0. Lets the bus settle. Next state: WRITE.
- WRITE (1 cycle): gnt[w]=1, read_en held, write_en = 1 << dst code, done=1. Next state: IDLE. ptr = (w+1) mod NREQ.
- ERR (1 cycle): gnt[w]=1, err=1, read_en=0, write_en=0. Next state: IDLE. ptr = (w+1) mod NREQ.
- Latency: req sampled high in IDLE at edge t. DRIVE outputs appear after edge t+1; the WRITE strobe and done appear after edge t+2. Minimum period is 3 cycles per transfer, because IDLE is always revisited.
- Codes are latched at the grant. Changes to src_sel or dst_sel during DRIVE or WRITE are ignored.
- If req drops mid-transfer, the transfer still completes; done is still pulsed.
- A requester that still holds req in the IDLE cycle after done re-enters arbitration. It is behind all others because the pointer has advanced.
- Simultaneous requests are resolved purely by ptr. No requester waits more than NREQ-1 transfers.
- Exactly one bit of write_en is high in WRITE; write_en is 0 in every other state. read_en is 0 whenever gnt is 0.
- Reset asserted during DRIVE or WRITE aborts the transfer: write_en drops immediately, no done pulse, ptr returns to 0.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, read_en=0, write_en=0, busy=0. Release -> first grant goes to req0.
- Single transfer: req[1]=1, src_sel slice1=5, dst slice1=7 -> DRIVE: gnt=4'b0010, read_en=5. WRITE: write_en=16'h0080, done=1. Then IDLE, ptr=2.
- Round robin: req=4'b1011 held continuously, all codes valid -> grant order 0,1,3,0,1,3. Each transfer is 3 cycles; done pulses 3 cycles apart.
- Invalid codes: req[2] with src=6 -> ERR cycle: gnt=4'b0100, err=1, read_en=0, write_en=0, no done. Repeat with src=13 and dst=0 -> ERR.
- Mid-transfer changes: change src_sel during DRIVE -> read_en unchanged. Drop req during DRIVE -> WRITE and done still occur.
- Async reset mid-WRITE: pull rst_n low between edges -> write_en=0 and busy=0 immediately, no done. After release, ptr=0.
